// File: rtl/spi_frame_decoder_if.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder_if
//
// Groups the word stream from the SPI slave shift stage, the single-cycle
// register-file port and the MISO return word into one bundle.
//
//   slave  modport : the frame decoder (consumes words, drives the register
//                    port, tx_data and frame_err)
//   master modport : the surrounding SPI stage / register file
//
// Signals:
//   in_valid   word-ready level, sclk domain (asynchronous to clk)
//   in_data    received 16-bit word
//   reg_we     register write strobe, one cycle wide
//   reg_re     register read strobe, one cycle wide
//   reg_addr   register address
//   reg_wdata  register write data
//   reg_rdata  register read data, valid one cycle after reg_re
//   tx_data    word to shift out on MISO during the next SPI word
//   frame_err  sticky framing error flag
// -----------------------------------------------------------------------------
interface spi_frame_decoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [15:0]       in_data;
    logic              reg_we;
    logic              reg_re;
    logic [ADDR_W-1:0] reg_addr;
    logic [15:0]       reg_wdata;
    logic [15:0]       reg_rdata;
    logic [15:0]       tx_data;
    logic              frame_err;

    modport slave (
        input  in_valid, in_data, reg_rdata,
        output reg_we, reg_re, reg_addr, reg_wdata, tx_data, frame_err
    );

    modport master (
        output in_valid, in_data, reg_rdata,
        input  reg_we, reg_re, reg_addr, reg_wdata, tx_data, frame_err
    );
endinterface

// File: rtl/spi_frame_decoder.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder
//
// Parses header + payload frames arriving as 16-bit words from the SPI slave
// shift stage, brings the word-ready level into the clk domain, and drives a
// single-cycle register port. Read data is returned on tx_data for the MISO
// shifter.
//
// Header word: [15] W (1 = write), [14:8] LEN (burst of LEN+1 words),
//              [7:0] start address (bits above ADDR_W must be zero).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    spi_frame_decoder_if.slave (word stream in, register port out,
//          tx_data and frame_err out)
//
// Parameters:
//   FPGA_CLK     system clock frequency in Hz (informational)
//   ADDR_W       register address width, 1..8
//   TIMEOUT_CYC  idle cycles allowed mid-frame before the frame is aborted
//
// Build option:
//   SPI_DEC_TIMEOUT_EN  when defined, a frame that sits idle for TIMEOUT_CYC
//                       cycles outside IDLE is aborted with frame_err set and
//                       tx_data forced to zero. When undefined, a partial
//                       frame waits indefinitely.
// -----------------------------------------------------------------------------
module spi_frame_decoder #(
    parameter int FPGA_CLK    = 12_000_000,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_frame_decoder_if.slave   bus
);

    if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
        $error("spi_frame_decoder: ADDR_W must be in 1..8");
    end
    if (FPGA_CLK <= 0) begin : g_bad_fpga_clk
        $error("spi_frame_decoder: FPGA_CLK must be positive");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("spi_frame_decoder: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_RCAP,
        S_RWAIT
    } state_e;

    // Header address bits that must be zero for the configured ADDR_W.
    localparam logic [7:0] ADDR_HI_MASK = 8'hFF << ADDR_W;

`ifdef SPI_DEC_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 13) ? $clog2(TIMEOUT_CYC + 1) : 13;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // in_valid synchroniser and edge register
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    // frame state
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;

    // registered outputs
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [15:0]       reg_wdata_q, reg_wdata_d;
    logic [15:0]       tx_data_q, tx_data_d;
    logic              frame_err_q, frame_err_d;

    logic              word_evt;
    logic              hdr_addr_ok;
    logic [ADDR_W-1:0] addr_nxt;

    // A word arrives on the rising edge of the synchronised in_valid.
    assign word_evt    = sync2_q & ~edge_q;
    assign hdr_addr_ok = (bus.in_data[7:0] & ADDR_HI_MASK) == 8'h00;
    assign addr_nxt    = addr_q + 1'b1;   // wraps mod 2^ADDR_W by width

    always_comb begin
        // NOTE: every signal gets its default first so no path through the
        // case statement can leave one unassigned and infer a latch.
        sync1_d     = bus.in_valid;
        sync2_d     = sync1_q;
        edge_d      = sync2_q;
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        tx_data_d   = tx_data_q;
        frame_err_d = frame_err_q;

        unique case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (word_evt) begin
                    if (!hdr_addr_ok) begin
                        // Out-of-range start address: flag and drop the frame.
                        frame_err_d = 1'b1;
                    end else begin
                        addr_d = bus.in_data[ADDR_W-1:0];
                        cnt_d  = bus.in_data[14:8];
                        if (bus.in_data[15]) begin
                            state_d = S_WDATA;
                        end else begin
                            reg_re_d   = 1'b1;
                            reg_addr_d = bus.in_data[ADDR_W-1:0];
                            state_d    = S_RCAP;
                        end
                    end
                end
            end

            S_WDATA: begin
                if (word_evt) begin
                    reg_we_d    = 1'b1;
                    reg_addr_d  = addr_q;
                    reg_wdata_d = bus.in_data;
                    if (cnt_q == 7'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_nxt;
                    end
                end
            end

            S_RCAP: begin
                // First RCAP cycle is the reg_re cycle; read data is valid in
                // the cycle after it, so capture only once reg_re has dropped.
                if (!reg_re_q) begin
                    tx_data_d = bus.reg_rdata;
                    state_d   = S_RWAIT;
                end
                // An early word is remembered and replayed in RWAIT; a second
                // one cannot be held and aborts the frame.
                if (word_evt) begin
                    if (pend_q) begin
                        frame_err_d = 1'b1;
                        pend_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end

            S_RWAIT: begin
                if (word_evt && pend_q) begin
                    frame_err_d = 1'b1;
                    pend_d      = 1'b0;
                    state_d     = S_IDLE;
                end else if (word_evt || pend_q) begin
                    pend_d = 1'b0;
                    if (cnt_q == 7'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d      = cnt_q - 1'b1;
                        addr_d     = addr_nxt;
                        reg_re_d   = 1'b1;
                        reg_addr_d = addr_nxt;
                        state_d    = S_RCAP;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

`ifdef SPI_DEC_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (state_q != S_IDLE && !word_evt) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Reaching TIMEOUT_CYC idle cycles overrides whatever the frame
            // logic decided this cycle.
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_cnt_d   = '0;
                frame_err_d = 1'b1;
                tx_data_d   = 16'h0000;
                reg_we_d    = 1'b0;
                reg_re_d    = 1'b0;
                pend_d      = 1'b0;
                state_d     = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchroniser resets to 1 because the SPI stage idles
            // with in_valid high; resetting to 0 would fake a word on release.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            edge_q      <= 1'b1;
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_data_q   <= 16'h0000;
            frame_err_q <= 1'b0;
`ifdef SPI_DEC_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_DEC_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.frame_err = frame_err_q;

endmodule
